// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between instruction fetch and data access, alternating
// priority when both request. Define MEM_TIMEOUT_EN to enable the bus-timeout counter and err flag.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          err
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_was_d;
    logic   if_pend, d_pend;
    logic   grant_if, grant_d, finish, tmo;

    // A requester whose done is pulsing still holds its req this cycle; it must not be re-granted.
    assign if_pend = if_req & ~if_done;
    assign d_pend  = d_req & ~d_done;
    assign stall   = if_pend | d_pend;

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (d_pend && (!if_pend || !last_was_d)) begin
                    grant_d   = 1'b1;
                    state_nxt = D_BUSY;
                end else if (if_pend) begin
                    grant_if  = 1'b1;
                    state_nxt = IF_BUSY;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (mem_ack || tmo) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_was_d <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_done    <= 1'b0;
            d_done     <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (grant_if) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end else if (finish) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (state == D_BUSY) begin
                    d_done     <= 1'b1;
                    last_was_d <= 1'b1;
                    // mem_we still holds the store flag of the finishing access
                    if (!mem_we) begin
                        d_rdata <= tmo ? '0 : mem_rdata;
                    end
                end else begin
                    if_done    <= 1'b1;
                    last_was_d <= 1'b0;
                    if_rdata   <= tmo ? '0 : mem_rdata;
                end
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       err_q;

    // Fires on the TIMEOUT-th consecutive cycle of mem_req without an ack.
    assign tmo = (state != IDLE) && !mem_ack && (tmo_cnt == 8'(TIMEOUT - 1));
    assign err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE || finish) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            if (tmo) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    logic [7:0] unused_timeout;

    assign unused_timeout = 8'(TIMEOUT);
    assign tmo            = 1'b0;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-stepped requester/memory model with grant and done
// scoreboards; timeout scenario is included when MEM_TIMEOUT_EN is defined.
module tb_mem_arbiter;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;
    localparam int GW      = 1 + AW + DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_done;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall;
    logic          err;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Expected grants {we, addr, wdata} and done pulses {if_done, d_done, rdata}, in order.
    logic [GW-1:0]   exp_q[$];
    logic [DW+1:0]   done_q[$];
    logic [GW-1:0]   cur_grant = '0;
    logic [DW+1:0]   exp_done;
    logic            req_prev = 1'b0;
    logic [DW-1:0]   resp_xor = '0;
    int              if_left = 0;
    int              d_left = 0;
    int              ack_delay = 0;
    int              ack_cnt = 0;
    int              tick_no = 0;
    int              req_hi = 0;
    int              last_hi = 0;
    int              req_tick = 0;
    int              done_tick = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: sample at the falling edge, score, then update requesters and memory model.
    task automatic tick();
        @(negedge clk);
        tick_no++;
        check("stall", stall, (if_req && !if_done) || (d_req && !d_done));
        if (mem_req && !req_prev) begin
            check("grant_avail", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) cur_grant = exp_q.pop_front();
            req_hi = 0;
        end
        if (!mem_req && req_prev) last_hi = req_hi;
        if (mem_req) begin
            req_hi++;
            check("mem_we", mem_we, cur_grant[GW-1]);
            check("mem_addr", mem_addr, cur_grant[AW+DW-1:DW]);
            if (cur_grant[GW-1]) check("mem_wdata", mem_wdata, cur_grant[DW-1:0]);
        end
        req_prev = mem_req;
        if (if_done || d_done) begin
            check("done_avail", done_q.size() > 0, 1'b1);
            if (done_q.size() > 0) begin
                exp_done = done_q.pop_front();
                check("done", {if_done, d_done, (if_done ? if_rdata : d_rdata)}, exp_done);
            end
        end
        if (d_done) begin
            done_tick = tick_no;
            if (d_left > 0) d_left--;
        end
        if (if_done && if_left > 0) if_left--;
        if (!d_req && d_left > 0) req_tick = tick_no;
        if_req = (if_left > 0);
        d_req  = (d_left > 0);
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (ack_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr ^ resp_xor;
                ack_cnt   = 0;
            end else begin
                ack_cnt++;
            end
        end else begin
            ack_cnt = 0;
        end
    endtask

    task automatic run(input int budget);
        logic done_ok;
        done_ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (if_left == 0 && d_left == 0 && !mem_req && done_q.size() == 0 && exp_q.size() == 0) begin
                done_ok = 1'b1;
                break;
            end
        end
        check("run_complete", done_ok, 1'b1);
        repeat (3) tick();
    endtask

    initial begin
        @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_if_done", if_done, 1'b0);
        check("rst_d_done", d_done, 1'b0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_err", err, 1'b0);
        check("rst_stall", stall, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Simultaneous load and fetch from reset: data first
        resp_xor = 32'h1111_0000; ack_delay = 1;
        d_we = 1'b0; d_addr = 32'h40; if_addr = 32'h200;
        exp_q.push_back({1'b0, 32'h40, 32'h0});
        exp_q.push_back({1'b0, 32'h200, 32'h0});
        done_q.push_back({2'b01, 32'h1111_0040});
        done_q.push_back({2'b10, 32'h1111_0200});
        d_left = 1; if_left = 1;
        run(40);

        // Store: d_rdata keeps the previous load value
        d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEAD_BEEF; ack_delay = 2;
        exp_q.push_back({1'b1, 32'h8, 32'hDEAD_BEEF});
        done_q.push_back({2'b01, 32'h1111_0040});
        d_left = 1;
        run(40);
        d_we = 1'b0;

        // Fetch with ack three cycles after mem_req
        resp_xor = 32'h2008_0105; ack_delay = 3; if_addr = 32'h100;
        exp_q.push_back({1'b0, 32'h100, 32'h0});
        done_q.push_back({2'b10, 32'h2008_0005});
        if_left = 1;
        run(40);
        check("fetch_req_cycles", last_hi, 4);
        check("if_rdata_hold", if_rdata, 32'h2008_0005);

        // Fairness: data held for three accesses, fetch pending for two
        resp_xor = 32'h0; ack_delay = 0; d_addr = 32'h300; if_addr = 32'h400;
        for (int k = 0; k < 5; k++) begin
            if (k % 2 == 0) begin
                exp_q.push_back({1'b0, 32'h300, 32'h0});
                done_q.push_back({2'b01, 32'h300});
            end else begin
                exp_q.push_back({1'b0, 32'h400, 32'h0});
                done_q.push_back({2'b10, 32'h400});
            end
        end
        d_left = 3; if_left = 2;
        run(100);

        // Minimum latency: request sampled in N, done visible in N+2
        resp_xor = 32'h5A5A_0000; ack_delay = 0; d_addr = 32'h44;
        exp_q.push_back({1'b0, 32'h44, 32'h0});
        done_q.push_back({2'b01, 32'h5A5A_0044});
        d_left = 1;
        run(20);
        check("min_latency", done_tick - req_tick, 2);

        // Ack while idle is ignored
        mem_rdata = 32'hBAD0_BAD0; mem_ack = 1'b1;
        repeat (4) tick();
        check("idle_ack_req", mem_req, 1'b0);
        check("idle_ack_d_rdata", d_rdata, 32'h5A5A_0044);
        check("idle_ack_if_rdata", if_rdata, 32'h400);

        // Reset mid-transaction
        ack_delay = 100000; d_addr = 32'h600;
        exp_q.push_back({1'b0, 32'h600, 32'h0});
        d_left = 1;
        repeat (3) tick();
        check("pre_reset_req", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("reset_req", mem_req, 1'b0);
        check("reset_dones", {if_done, d_done}, 2'b00);
        check("reset_d_rdata", d_rdata, 32'h0);
        d_left = 0; d_req = 1'b0; ack_cnt = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_reset_req", mem_req, 1'b0);
        check("post_reset_grants", exp_q.size(), 0);

        // After reset, priority restarts with data first
        resp_xor = 32'h0; ack_delay = 0; d_addr = 32'h610; if_addr = 32'h700;
        exp_q.push_back({1'b0, 32'h610, 32'h0});
        exp_q.push_back({1'b0, 32'h700, 32'h0});
        done_q.push_back({2'b01, 32'h610});
        done_q.push_back({2'b10, 32'h700});
        d_left = 1; if_left = 1;
        run(40);

`ifdef MEM_TIMEOUT_EN
        ack_delay = 100000; if_addr = 32'h500;
        exp_q.push_back({1'b0, 32'h500, 32'h0});
        done_q.push_back({2'b10, 32'h0});
        if_left = 1;
        run(60);
        check("tmo_req_cycles", last_hi, TIMEOUT);
        check("tmo_err", err, 1'b1);
        repeat (5) tick();
        check("tmo_err_sticky", err, 1'b1);
        rst_n = 1'b0;
        #1;
        check("tmo_err_reset", err, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();
`else
        check("err_tied", err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max cycles to wait for mem_ack (range 2..255).
REQ-004 SHALL have ports:
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  reset, asynchronous, active-low
  if_req  in  1  instruction fetch request, held until if_done
  if_addr  in  AW  fetch address
  if_done  out  1  one-cycle pulse, fetch complete
  if_rdata  out  DW  fetched word, valid with if_done
  d_req  in  1  data request (lw/sw), held until d_done
  d_we  in  1  1 = store, 0 = load
  d_addr  in  AW  data address
  d_wdata  in  DW  store data
  d_done  out  1  one-cycle pulse, data access complete
  d_rdata  out  DW  load data, valid with d_done
  mem_req  out  1  bus request, held until mem_ack
  mem_we  out  1  bus write enable
  mem_addr  out  AW  bus address
  mem_wdata  out  DW  bus write data
  mem_ack  in  1  bus completion, one cycle
  mem_rdata  in  DW  bus read data, valid with mem_ack
  stall  out  1  pipeline stall request
  err  out  1  sticky timeout flag (MEM_TIMEOUT_EN only; else tied 0)

Function
REQ-005 SHALL implement FSM states IDLE, IF_BUSY, D_BUSY.
REQ-006 IDLE: d_req only -> D_BUSY; if_req only -> IF_BUSY; both -> D_BUSY unless last_was_d=1, then IF_BUSY; neither -> IDLE.
REQ-007 last_was_d SHALL be set on completion of a data access, cleared on completion of a fetch (alternating fairness; no requester starves).
REQ-008 mem_req, mem_we, mem_addr, mem_wdata SHALL be registered, driven the cycle after the grant decision, and held stable until the cycle mem_ack is sampled.
REQ-009 mem_we SHALL be 0 in IF_BUSY and equal d_we in D_BUSY.
REQ-010 On mem_ack in X_BUSY: FSM -> IDLE, mem_req deasserts next cycle, X_done pulses for exactly one cycle next cycle with X_rdata = captured mem_rdata.
REQ-011 Minimum latency: request sampled in cycle N, mem_req high in N+1, mem_ack in N+1 gives done in N+2.
REQ-012 IDLE SHALL last at least one cycle between transactions; mem_req SHALL never be high for two transactions back-to-back without one low cycle.
REQ-013 mem_ack while IDLE SHALL be ignored.
REQ-014 if_rdata/d_rdata SHALL hold their last value until the next respective done.
REQ-015 stall = (if_req & ~if_done) | (d_req & ~d_done), combinational.
REQ-016 d_rdata on a store completion SHALL be unchanged.

Reset
REQ-017 rst_n low SHALL asynchronously force IDLE, last_was_d=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_done=0, d_done=0, if_rdata=0, d_rdata=0, err=0, timeout counter=0.
REQ-018 Reset mid-transaction SHALL abort it with no done pulse; arbitration restarts from IDLE after release.

Configuration
REQ-019 With MEM_TIMEOUT_EN defined: an 8-bit counter SHALL count cycles of mem_req high without mem_ack; on reaching TIMEOUT, FSM -> IDLE, mem_req drops, the requester's done pulses with rdata=0, and err sets (sticky until reset).
REQ-020 Without MEM_TIMEOUT_EN: no counter; the arbiter waits indefinitely for mem_ack; err SHALL be constant 0.

Verification
REQ-021 Fetch only: if_req=1, if_addr=0x100, mem_ack 3 cycles after mem_req with rdata=0x20080005 -> mem_we=0, mem_addr=0x100, if_done one cycle later, if_rdata=0x20080005.
REQ-022 Simultaneous: if_req and d_req (load 0x40) in same cycle from reset -> data served first, then fetch; d_done precedes if_done; stall high throughout.
REQ-023 Fairness: d_req held continuously for 3 transactions with if_req pending -> grant order D, IF, D, IF.
REQ-024 Store: d_req, d_we=1, d_addr=0x8, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, d_done after ack, d_rdata unchanged.
REQ-025 Reset mid-op: rst_n low while mem_req=1 -> mem_req=0 immediately, no done pulse, FSM IDLE.
REQ-026 MEM_TIMEOUT_EN, TIMEOUT=16: mem_ack never asserted -> after 16 cycles mem_req=0, done pulse with rdata=0, err=1 held until reset.
